display_scan: RTL and testbench

Time-multiplexing scanner for the two-digit seven-segment display. It latches two hex values plus decimal points from the datapath and encodes them into active-low segment patterns. It drives the active-low digit select that the downstream digit multiplexer uses to route one pattern to the shared segment bus. A double-buffered load commits new values only at frame boundaries, so a digit pair never tears mid-frame.

---
 rtl/display_scan_if.sv | 15 +
 rtl/display_scan.sv | 151 +++++++++++++++
 tb/tb_display_scan.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Datapath-facing bundle for the two-digit scanner: load strobe and values in,
// segment patterns, digit select and frame pulse out.
interface display_scan_if;
    logic       load;
    logic [3:0] val1;
    logic [3:0] val2;
    logic [1:0] dp;
    logic [7:0] nro1;
    logic [7:0] nro2;
    logic [1:0] sel;
    logic       frame;

    modport master (output load, val1, val2, dp, input nro1, nro2, sel, frame);
    modport slave  (input load, val1, val2, dp, output nro1, nro2, sel, frame);
endinterface

// File: rtl/display_scan.sv
// Two-digit seven-segment scanner with frame-aligned double-buffered load; SCAN_BLANK_EN adds a blank slot before each digit.
// Load-to-display latency 1..2*DIV cycles; no backpressure, load is always accepted.
module display_scan #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic          clk,
    input  logic          rst,
    display_scan_if.slave bus
);
    localparam int CW = $clog2(DIV);

`ifdef SCAN_BLANK_EN
    localparam int BLANK_USED = BLANK;
`else
    localparam int BLANK_USED = 0;
`endif
    localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - BLANK_USED - 1);

    typedef enum logic [1:0] {
        S_BLANK1 = 2'd0,
        S_SHOW1  = 2'd1,
        S_BLANK2 = 2'd2,
        S_SHOW2  = 2'd3
    } state_t;

`ifdef SCAN_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_USED - 1);
    localparam state_t        RST_STATE  = S_BLANK1;
    localparam logic [1:0]    RST_SEL    = 2'b11;
`else
    localparam state_t        RST_STATE  = S_SHOW1;
    localparam logic [1:0]    RST_SEL    = 2'b10;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [3:0]    pv1_q, pv1_d;
    logic [3:0]    pv2_q, pv2_d;
    logic [1:0]    pdp_q, pdp_d;
    logic [7:0]    nro1_q, nro1_d;
    logic [7:0]    nro2_q, nro2_d;
    logic [1:0]    sel_q, sel_d;
    logic          frame_q, frame_d;
    logic          commit;

    function automatic logic [7:0] enc(input logic [3:0] v, input logic d);
        logic [6:0] seg;
        seg = 7'h7F;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'h7F;
        endcase
        return {~d, seg};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
`ifdef SCAN_BLANK_EN
            S_BLANK1: if (cnt_q == BLANK_LAST) state_d = S_SHOW1;
            S_SHOW1:  if (cnt_q == SHOW_LAST)  state_d = S_BLANK2;
            S_BLANK2: if (cnt_q == BLANK_LAST) state_d = S_SHOW2;
            S_SHOW2:  if (cnt_q == SHOW_LAST)  state_d = S_BLANK1;
`else
            S_SHOW1:  if (cnt_q == SHOW_LAST)  state_d = S_SHOW2;
            S_SHOW2:  if (cnt_q == SHOW_LAST)  state_d = S_SHOW1;
`endif
            default:  state_d = RST_STATE;
        endcase
        if (state_d != state_q) cnt_d = '0;

        // Leaving SHOW2 is always the frame-start edge, in either build.
        commit  = (state_q == S_SHOW2) && (state_d != S_SHOW2);
        frame_d = commit;

        // Registered from next state so the select never glitches through 2'b00.
        case (state_d)
            S_SHOW1: sel_d = 2'b10;
            S_SHOW2: sel_d = 2'b01;
            default: sel_d = 2'b11;
        endcase

        pv1_d  = pv1_q;
        pv2_d  = pv2_q;
        pdp_d  = pdp_q;
        pend_d = pend_q;
        nro1_d = nro1_q;
        nro2_d = nro2_q;
        if (commit && pend_q) begin
            nro1_d = enc(pv1_q, pdp_q[0]);
            nro2_d = enc(pv2_q, pdp_q[1]);
            pend_d = 1'b0;
        end
        // A load on the commit edge lands after the old contents were consumed.
        if (bus.load) begin
            pv1_d  = bus.val1;
            pv2_d  = bus.val2;
            pdp_d  = bus.dp;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pv1_q   <= '0;
            pv2_q   <= '0;
            pdp_q   <= '0;
            nro1_q  <= 8'hFF;
            nro2_q  <= 8'hFF;
            sel_q   <= RST_SEL;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pv1_q   <= pv1_d;
            pv2_q   <= pv2_d;
            pdp_q   <= pdp_d;
            nro1_q  <= nro1_d;
            nro2_q  <= nro2_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
        end
    end

    assign bus.nro1  = nro1_q;
    assign bus.nro2  = nro2_q;
    assign bus.sel   = sel_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan at DIV=8, BLANK=2; works with or without SCAN_BLANK_EN.
// Loads feed an expected-display queue that is drained on each frame start.
module tb_display_scan;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 2 * DIV;

`ifdef SCAN_BLANK_EN
    localparam logic [1:0] RST_SEL = 2'b11;
`else
    localparam logic [1:0] RST_SEL = 2'b10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   edge_no = 0;

    logic [15:0] exp_q[$];
    logic [15:0] shown = 16'hFFFF;
    bit          tail_pending = 1'b0;

    display_scan_if bus ();

    display_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_no <= 0;
        else     edge_no <= edge_no + 1;
    end

    function automatic logic [7:0] ref_enc(input logic [3:0] v, input logic d);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return {~d, s};
    endfunction

    function automatic logic [1:0] ref_sel(input int pos);
`ifdef SCAN_BLANK_EN
        if (pos < BLANK)                 return 2'b11;
        if (pos < DIV)                   return 2'b10;
        if (pos < DIV + BLANK)           return 2'b11;
        return 2'b01;
`else
        return (pos < DIV) ? 2'b10 : 2'b01;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, expv, edge_no);
        end
    endtask

    // Per-cycle monitor: sel/frame follow the frame position, nro follows the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            int  pos;
            bit  exp_frame;
            pos       = edge_no % FRAME;
            exp_frame = (pos == 0) && (edge_no != 0);
            if (exp_frame && exp_q.size() > 0) begin
                shown        = exp_q.pop_front();
                tail_pending = (exp_q.size() > 0);
            end
            check("sel",   {14'd0, bus.sel},   {14'd0, ref_sel(pos)});
            check("frame", {15'd0, bus.frame}, {15'd0, exp_frame});
            check("nro",   {bus.nro1, bus.nro2}, shown);
        end
    end

    task automatic wait_edge(input int n);
        while (edge_no < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic do_load(input logic [3:0] v1, input logic [3:0] v2, input logic [1:0] d);
        logic [15:0] e;
        bit          on_commit;
        e         = {ref_enc(v1, d[0]), ref_enc(v2, d[1])};
        on_commit = ((edge_no + 1) % FRAME) == 0;
        if (tail_pending && !on_commit) void'(exp_q.pop_back());
        exp_q.push_back(e);
        tail_pending = 1'b1;
        bus.load = 1'b1;
        bus.val1 = v1;
        bus.val2 = v2;
        bus.dp   = d;
        @(posedge clk);
        #2;
        bus.load = 1'b0;
    endtask

    initial begin
        #50000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load = 1'b0;
        bus.val1 = 4'h0;
        bus.val2 = 4'h0;
        bus.dp   = 2'b00;

        #12;
        check("rst_sel",   {14'd0, bus.sel},     {14'd0, RST_SEL});
        check("rst_nro",   {bus.nro1, bus.nro2}, 16'hFFFF);
        check("rst_frame", {15'd0, bus.frame},   16'd0);
        #10 rst = 1'b0;

        wait_edge(35);
        do_load(4'h3, 4'hA, 2'b01);
        wait_edge(52);
        do_load(4'h1, 4'h2, 2'b00);
        wait_edge(56);
        do_load(4'h5, 4'h6, 2'b00);
        wait_edge(70);
        do_load(4'h9, 4'h0, 2'b00);
        wait_edge(79);
        do_load(4'h7, 4'h8, 2'b00);

        wait_edge(100);
        check("all_committed", 16'(exp_q.size()), 16'd0);
        do_load(4'hB, 4'hC, 2'b11);

        // Asynchronous reset mid-SHOW2 with 7/8 shown and B/C pending.
        wait_edge(108);
        check("pre_rst_nro", {bus.nro1, bus.nro2}, {ref_enc(4'h7, 1'b0), ref_enc(4'h8, 1'b0)});
        #1 rst = 1'b1;
        #1;
        check("async_rst_sel",   {14'd0, bus.sel},     {14'd0, RST_SEL});
        check("async_rst_nro",   {bus.nro1, bus.nro2}, 16'hFFFF);
        check("async_rst_frame", {15'd0, bus.frame},   16'd0);
        exp_q.delete();
        shown        = 16'hFFFF;
        tail_pending = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        wait_edge(2 * FRAME + 4);
        check("pending_lost", {bus.nro1, bus.nro2}, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
